// File: rtl/tx_frame_serializer.sv
// Frames buffered stream words into header / MSB-first data bytes / XOR checksum
// for a byte-wide UART transmitter, with a word-level rdy/ack handshake on the input side.
`timescale 1ns/1ps
module tx_frame_serializer #(
    parameter int         TX_DATA_WIDTH = 16,
    parameter logic [7:0] HEADER_BYTE   = 8'hA5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TX_DATA_WIDTH-1:0] data_in,
    input  logic                     data_rdy,
    input  logic                     data_eof,
    output logic                     data_ack,
    output logic [7:0]               tx_byte,
    output logic                     tx_byte_rdy,
    input  logic                     tx_byte_ack,
    output logic                     busy,
    output logic                     frame_done,
    output logic [15:0]              frame_words
);

    localparam int         BYTES    = TX_DATA_WIDTH / 8;
    localparam logic [2:0] LAST_IDX = 3'(BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        WAIT_WORD,
        SEND,
        CHECKSUM
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               tx_byte_q, tx_byte_d;
    logic                     tx_rdy_q, tx_rdy_d;
    logic                     data_ack_q, data_ack_d;
    logic                     frame_done_q, frame_done_d;
    logic [15:0]              frame_words_q, frame_words_d;
    logic                     busy_q, busy_d;
    logic [7:0]               csum_q, csum_d;
    logic [15:0]              wcnt_q, wcnt_d;
    logic [2:0]               idx_q, idx_d;
    logic                     eof_q, eof_d;
    logic [TX_DATA_WIDTH-1:0] shift_q, shift_d;
    logic                     xfer;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign xfer = tx_rdy_q & tx_byte_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (data_rdy) state_d = HEADER;
            HEADER:    if (xfer)     state_d = WAIT_WORD;
            WAIT_WORD: if (data_rdy) state_d = SEND;
            SEND:      if (xfer && idx_q >= LAST_IDX) state_d = eof_q ? CHECKSUM : WAIT_WORD;
            CHECKSUM:  if (xfer)     state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_byte_d     = tx_byte_q;
        tx_rdy_d      = tx_rdy_q;
        data_ack_d    = 1'b0;
        frame_done_d  = 1'b0;
        frame_words_d = frame_words_q;
        csum_d        = csum_q;
        wcnt_d        = wcnt_q;
        idx_d         = idx_q;
        eof_d         = eof_q;
        shift_d       = shift_q;
        case (state_q)
            IDLE: if (data_rdy) begin
                tx_byte_d = HEADER_BYTE;
                tx_rdy_d  = 1'b1;
                csum_d    = 8'h00;
                wcnt_d    = 16'h0000;
            end
            HEADER: if (xfer) tx_rdy_d = 1'b0;
            WAIT_WORD: if (data_rdy) begin
                shift_d    = data_in << 8;
                eof_d      = data_eof;
                data_ack_d = 1'b1;
                idx_d      = 3'd0;
                tx_byte_d  = data_in[TX_DATA_WIDTH-1 -: 8];
                tx_rdy_d   = 1'b1;
                wcnt_d     = sat_inc(wcnt_q);
            end
            SEND: if (xfer) begin
                csum_d = csum_q ^ tx_byte_q;
                if (idx_q < LAST_IDX) begin
                    tx_byte_d = shift_q[TX_DATA_WIDTH-1 -: 8];
                    shift_d   = shift_q << 8;
                    idx_d     = idx_q + 3'd1;
                end else if (eof_q) begin
                    // Checksum is presented on entry so it costs a single cycle.
                    tx_byte_d = csum_q ^ tx_byte_q;
                    tx_rdy_d  = 1'b1;
                end else begin
                    tx_rdy_d  = 1'b0;
                end
            end
            CHECKSUM: if (xfer) begin
                tx_rdy_d      = 1'b0;
                frame_done_d  = 1'b1;
                frame_words_d = wcnt_q;
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_byte_q     <= 8'h00;
            tx_rdy_q      <= 1'b0;
            data_ack_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_words_q <= 16'h0000;
            busy_q        <= 1'b0;
            csum_q        <= 8'h00;
            wcnt_q        <= 16'h0000;
            idx_q         <= 3'd0;
            eof_q         <= 1'b0;
        end else begin
            tx_byte_q     <= tx_byte_d;
            tx_rdy_q      <= tx_rdy_d;
            data_ack_q    <= data_ack_d;
            frame_done_q  <= frame_done_d;
            frame_words_q <= frame_words_d;
            busy_q        <= busy_d;
            csum_q        <= csum_d;
            wcnt_q        <= wcnt_d;
            idx_q         <= idx_d;
            eof_q         <= eof_d;
        end
    end

    // Word shifter is pure datapath; it is always reloaded before use.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign data_ack    = data_ack_q;
    assign tx_byte     = tx_byte_q;
    assign tx_byte_rdy = tx_rdy_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_words = frame_words_q;

endmodule

// File: tb/tb_tx_frame_serializer.sv
// Directed bench for tx_frame_serializer: a 16-bit instance for framing, stalls, gaps
// and reset, and an 8-bit instance for a long odd-length frame.
`timescale 1ns/1ps
module tb_tx_frame_serializer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [15:0] d16 = '0;
    logic        rdy16 = 1'b0, eof16 = 1'b0, uack16 = 1'b0;
    logic        dack16, txr16, busy16, fd16;
    logic [7:0]  tx16;
    logic [15:0] fw16;

    logic [7:0]  d8 = '0;
    logic        rdy8 = 1'b0, eof8 = 1'b0, uack8 = 1'b1;
    logic        dack8, txr8, busy8, fd8;
    logic [7:0]  tx8;
    logic [15:0] fw8;

    tx_frame_serializer #(.TX_DATA_WIDTH(16), .HEADER_BYTE(8'hA5)) dut16 (
        .clk(clk), .rst(rst), .data_in(d16), .data_rdy(rdy16), .data_eof(eof16),
        .data_ack(dack16), .tx_byte(tx16), .tx_byte_rdy(txr16), .tx_byte_ack(uack16),
        .busy(busy16), .frame_done(fd16), .frame_words(fw16));

    tx_frame_serializer #(.TX_DATA_WIDTH(8), .HEADER_BYTE(8'hA5)) dut8 (
        .clk(clk), .rst(rst), .data_in(d8), .data_rdy(rdy8), .data_eof(eof8),
        .data_ack(dack8), .tx_byte(tx8), .tx_byte_rdy(txr8), .tx_byte_ack(uack8),
        .busy(busy8), .frame_done(fd8), .frame_words(fw8));

    int vectors = 0;
    int miscompares = 0;

    // UART ack pattern: 0 = always high, 1 = high every third cycle
    int ack_mode = 0;
    int cyc = 0;
    initial forever begin
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        uack16 = (ack_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end

    // Transfer / pulse monitors, sampled mid-cycle
    logic [7:0] log16[$];
    int   dack16_n = 0, fd16_n = 0;
    int   stall_viol = 0, stall_obs = 0;
    logic stall_chk = 1'b0;
    logic prev_rdy = 1'b0, prev_ack = 1'b0;
    logic [7:0] prev_byte = 8'h00;
    int   n8 = 0, dack8_n = 0, fd8_n = 0;
    logic [7:0] first8 = 8'h00, last8 = 8'h00;

    always @(negedge clk) begin
        if (txr16 && uack16) log16.push_back(tx16);
        if (dack16) dack16_n <= dack16_n + 1;
        if (fd16)   fd16_n   <= fd16_n + 1;
        if (stall_chk && prev_rdy && !prev_ack) begin
            stall_obs <= stall_obs + 1;
            if (!txr16 || tx16 != prev_byte) stall_viol <= stall_viol + 1;
        end
        prev_rdy  <= txr16;
        prev_ack  <= uack16;
        prev_byte <= tx16;
        if (txr8 && uack8) begin
            n8 <= n8 + 1;
            if (n8 == 0) first8 <= tx8;
            last8 <= tx8;
        end
        if (dack8) dack8_n <= dack8_n + 1;
        if (fd8)   fd8_n   <= fd8_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (got === exp) else begin
            miscompares = miscompares + 1;
            $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic push16(input logic [15:0] w, input logic e);
        int n = 0;
        d16 = w; eof16 = e; rdy16 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!dack16 && n < 200);
        chk("ack16_seen", 32'(dack16), 32'd1);
        @(posedge clk);
        #1;
        rdy16 = 1'b0; eof16 = 1'b0;
    endtask

    task automatic push8(input logic [7:0] w, input logic e);
        int n = 0;
        d8 = w; eof8 = e; rdy8 = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!dack8 && n < 200);
        if (!dack8) chk("ack8_seen", 32'(dack8), 32'd1);
        @(posedge clk);
        #1;
        rdy8 = 1'b0; eof8 = 1'b0;
    endtask

    task automatic wait_fd16(input int target);
        int n = 0;
        while (fd16_n < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("fd16_count", 32'(fd16_n), 32'(target));
    endtask

    task automatic chk_bytes(input string tag, input int base, input int len, input logic [63:0] exp);
        logic [31:0] got;
        chk({tag, "_len"}, 32'(log16.size() - base), 32'(len));
        for (int i = 0; i < len; i++) begin
            got = (base + i < log16.size()) ? 32'(log16[base + i]) : 32'hDEAD;
            chk({tag, "_byte"}, got, 32'(exp[8*(len-1-i) +: 8]));
        end
    endtask

    initial begin
        int base, dbase;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx_byte", 32'(tx16), 32'h00);
        chk("rst_tx_rdy", 32'(txr16), 32'd0);
        chk("rst_busy", 32'(busy16), 32'd0);
        chk("rst_ack", 32'(dack16), 32'd0);
        chk("rst_fd", 32'(fd16), 32'd0);
        chk("rst_fw", 32'(fw16), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two-word frame, UART always ready
        ack_mode = 0;
        #1;
        base = log16.size(); dbase = dack16_n;
        push16(16'h1234, 1'b0);
        push16(16'hABCD, 1'b1);
        wait_fd16(1);
        chk_bytes("A", base, 6, 64'hA5_12_34_AB_CD_40);
        chk("A_acks", 32'(dack16_n - dbase), 32'd2);
        chk("A_fw", 32'(fw16), 32'd2);
        chk("A_busy", 32'(busy16), 32'd0);

        // Single word, UART accepts every third cycle; output must hold during stalls
        ack_mode = 1;
        stall_chk = 1'b1;
        #1;
        base = log16.size();
        push16(16'h00FF, 1'b1);
        wait_fd16(2);
        stall_chk = 1'b0;
        chk_bytes("B", base, 4, 64'hA5_00_FF_FF);
        chk("B_fw", 32'(fw16), 32'd1);
        chk("B_stall_viol", 32'(stall_viol), 32'd0);
        chk("B_stalls_seen", 32'(stall_obs > 0), 32'd1);

        // Source gap of 10 cycles between words; UART ack stays high throughout
        ack_mode = 0;
        repeat (2) @(negedge clk);
        #1;
        base = log16.size(); dbase = dack16_n;
        push16(16'h1234, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("C_gap_rdy", 32'(txr16), 32'd0);
            if (i == 8) chk("C_gap_busy", 32'(busy16), 32'd1);
        end
        #1;
        chk("C_gap_acks", 32'(dack16_n - dbase), 32'd1);
        push16(16'h5678, 1'b1);
        wait_fd16(3);
        chk_bytes("C", base, 6, 64'hA5_12_34_56_78_08);
        chk("C_acks", 32'(dack16_n - dbase), 32'd2);
        chk("C_fw", 32'(fw16), 32'd2);

        // Reset after the first data byte of a word
        repeat (2) @(negedge clk);
        push16(16'hC35A, 1'b1);
        chk("D_pre_busy", 32'(busy16), 32'd1);
        chk("D_pre_byte", 32'(tx16), 32'h5A);
        rst = 1'b1;
        #1;
        chk("D_rst_tx_byte", 32'(tx16), 32'h00);
        chk("D_rst_tx_rdy", 32'(txr16), 32'd0);
        chk("D_rst_busy", 32'(busy16), 32'd0);
        chk("D_rst_fd", 32'(fd16), 32'd0);
        chk("D_rst_fw", 32'(fw16), 32'd0);
        chk("D_rst_ack", 32'(dack16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #1;
        base = log16.size();
        push16(16'h0102, 1'b1);
        wait_fd16(4);
        chk_bytes("D", base, 4, 64'hA5_01_02_03);
        chk("D_fw", 32'(fw16), 32'd1);

        // UART ack toggling while idle must not start anything
        ack_mode = 1;
        repeat (2) @(negedge clk);
        #1;
        base = log16.size();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("E_idle_busy", 32'(busy16), 32'd0);
            chk("E_idle_rdy", 32'(txr16), 32'd0);
        end
        #1;
        chk("E_idle_log", 32'(log16.size() - base), 32'd0);
        chk("E_idle_fd", 32'(fd16_n), 32'd4);

        // 8-bit instance: 301 words of 5A, odd count leaves 5A as checksum
        for (int i = 0; i < 300; i++) push8(8'h5A, 1'b0);
        push8(8'h5A, 1'b1);
        for (int i = 0; i < 20 && fd8_n == 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("F_fd", 32'(fd8_n), 32'd1);
        chk("F_bytes", 32'(n8), 32'd303);
        chk("F_first", 32'(first8), 32'hA5);
        chk("F_csum", 32'(last8), 32'h5A);
        chk("F_acks", 32'(dack8_n), 32'd301);
        chk("F_fw", 32'(fw8), 32'd301);
        chk("F_busy", 32'(busy8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tx_frame_serializer.md
# tx_frame_serializer

Consumer end of the channel transmit stream (data / rdy / eof / ack): accepts buffered sample words from a channel's RAM controller and serializes them, MSB byte first, into framed bytes for the byte-wide UART transmitter. It sits between the channel blocks' tx outputs and the UART TX. Each frame is a header byte, all data bytes, and a trailing XOR checksum byte.

## Interface
Parameters:
- TX_DATA_WIDTH, 16, width of one stream word; multiple of 8, range 8..32; BYTES = TX_DATA_WIDTH/8
- HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- data_in  input  TX_DATA_WIDTH  stream word, valid while data_rdy=1
- data_rdy  input  1  source has a word; held with data_in/data_eof until data_ack seen
- data_eof  input  1  marks the word on data_in as the last of the frame (qualified by data_rdy)
- data_ack  output  1  one-cycle pulse: word captured
- tx_byte  output  8  byte to UART
- tx_byte_rdy  output  1  tx_byte valid
- tx_byte_ack  input  1  UART accepts tx_byte; transfer = edge with tx_byte_rdy & tx_byte_ack
- busy  output  1  frame in progress (state ≠ IDLE)
- frame_done  output  1  one-cycle pulse after checksum byte transferred
- frame_words  output  16  words in last completed frame, saturates at 16'hFFFF

## Operation
- States: IDLE, HEADER, WAIT_WORD, SEND, CHECKSUM.
- IDLE: on edge with data_rdy=1 -> HEADER; tx_byte<=HEADER_BYTE, tx_byte_rdy<=1, checksum<=0, word counter<=0. No word captured yet.
- HEADER: on transfer -> WAIT_WORD, tx_byte_rdy<=0.
- WAIT_WORD: on edge with data_rdy=1: shift reg<=data_in, eof flag<=data_eof, data_ack<=1 (for one cycle), byte index<=0, tx_byte<=data_in[TX_DATA_WIDTH-1 -: 8], tx_byte_rdy<=1, word counter +1 (saturating) -> SEND. data_rdy=0: wait indefinitely.
- SEND: on each transfer, checksum ^= tx_byte; if byte index < BYTES-1, present next lower byte next cycle (tx_byte_rdy stays 1), index +1; else tx_byte_rdy<=0 and -> CHECKSUM if eof flag, else -> WAIT_WORD.
- CHECKSUM: entry presents tx_byte = accumulated checksum (including last data byte), tx_byte_rdy=1; on transfer -> IDLE, tx_byte_rdy<=0, frame_done<=1, frame_words<=word counter.
- Checksum covers data bytes only, not header.
- data_in sampled only in WAIT_WORD; data_rdy in other states ignored (no double capture).
- tx_byte_ack while tx_byte_rdy=0 ignored.

## Timing
- All outputs registered. Reset values: data_ack=0, tx_byte=8'h00, tx_byte_rdy=0, busy=0, frame_done=0, frame_words=0; state IDLE, checksum 0.
- Reset mid-frame: immediate return to IDLE, in-flight frame dropped, frame_words cleared to 0.
- data_ack is high in the cycle after the capture edge; source updates data/rdy/eof at the edge it sees ack, so a new word is visible by the next WAIT_WORD sample.
- With tx_byte_ack held high: header 1 cycle, each word BYTES cycles in SEND + 1 cycle in WAIT_WORD, checksum 1 cycle; frame of N words = 2 + N·(BYTES+1) cycles from IDLE exit to frame_done edge, plus 1 IDLE detect cycle.
- tx_byte/tx_byte_rdy stable while tx_byte_rdy=1 and no transfer.
- eof on first word: valid 1-word frame. TX_DATA_WIDTH=8: SEND lasts one transfer per word.
- frame_done and a new IDLE->HEADER detect can't overlap: frame_done pulses in IDLE cycle; a new frame may start on that same edge if data_rdy=1.

## Test plan
- Width 16, ack always 1, words 16'h1234, 16'hABCD(eof) -> bytes A5,12,34,AB,CD,checksum 8'h40 (12^34^AB^CD); two data_ack pulses; frame_done once; frame_words=2.
- Single word 16'h00FF with eof, UART ack asserted every 3rd cycle -> bytes A5,00,FF,FF; tx_byte stable during each stall; frame_words=1.
- Source delays data_rdy 10 cycles between words -> block idles in WAIT_WORD, tx_byte_rdy=0, no extra data_ack, frame correct.
- Assert rst while in SEND after 1 byte -> all outputs at reset values asynchronously; next frame starts cleanly with A5, checksum restarted at 0.
- TX_DATA_WIDTH=8, 300 words 8'h5A then eof word 8'h5A -> 303 bytes sent, checksum 8'h5A (301 odd count), frame_words=301.
- tx_byte_ack pulses while idle and during WAIT_WORD -> no state change, no spurious transfers or checksum updates.
